pc_gen_btb: RTL and testbench

//  Next-generation PC generator for the IF stage: architectural PC register with parametrised width and

---
 rtl/pc_gen_btb.sv | 115 +++++++++++
 tb/tb_pc_gen_btb.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_gen_btb.sv
// IF-stage next-PC generator: architectural PC, valid/ready fetch handshake and
// a direct-mapped BTB that predicts taken control flow from the current fetch PC.
module pc_gen_btb #(
  parameter int unsigned XLEN      = 64,
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter int unsigned BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            stall_en_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  output logic            misalign_o,
  input  logic            upd_en_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [XLEN-1:0]      r_pc;
  logic                 r_fetch_valid;
  logic                 r_misalign;
  logic [BTB_DEPTH-1:0] r_btb_valid;
  logic [TAG_W-1:0]     r_btb_tag [BTB_DEPTH];
  logic [XLEN-3:0]      r_btb_tgt [BTB_DEPTH];

  logic [IDX_W-1:0]     w_rd_idx;
  logic [TAG_W-1:0]     w_rd_tag;
  logic                 w_hit;
  logic [XLEN-1:0]      w_pc_plus4;
  logic [XLEN-1:0]      w_pred_target;
  logic                 w_fire;
  logic [XLEN-1:0]      w_pc_next;
  logic                 w_misalign_next;
  logic [IDX_W-1:0]     w_upd_idx;
  logic [TAG_W-1:0]     w_upd_tag;
  logic                 w_upd_tag_match;
  logic                 w_unused_bits;

  // Targets are word aligned, so the two low address bits of training inputs carry no information.
  assign w_unused_bits = &{1'b0, upd_pc_i[1:0], upd_target_i[1:0]};

  assign w_rd_idx        = r_pc[IDX_W+1:2];
  assign w_rd_tag        = r_pc[XLEN-1:IDX_W+2];
  assign w_hit           = r_btb_valid[w_rd_idx] & (r_btb_tag[w_rd_idx] == w_rd_tag);
  assign w_pc_plus4      = r_pc + {{(XLEN-3){1'b0}}, 3'd4};
  assign w_pred_target   = w_hit ? {r_btb_tgt[w_rd_idx], 2'b00} : w_pc_plus4;
  assign w_fire          = r_fetch_valid & fetch_ready_i;

  assign w_upd_idx       = upd_pc_i[IDX_W+1:2];
  assign w_upd_tag       = upd_pc_i[XLEN-1:IDX_W+2];
  assign w_upd_tag_match = (r_btb_tag[w_upd_idx] == w_upd_tag);

  // Next-PC selection: redirect beats stall, stall beats an accepted fetch.
  always_comb begin
    w_pc_next       = r_pc;
    w_misalign_next = 1'b0;
    if (jump_en_i) begin
      w_pc_next       = {jump_addr_i[XLEN-1:2], 2'b00};
      w_misalign_next = |jump_addr_i[1:0];
    end else if (stall_en_i) begin
      w_pc_next = r_pc;
    end else if (w_fire) begin
      w_pc_next = w_pred_target;
    end else begin
      w_pc_next = r_pc;
    end
  end

  // PC, handshake, misalign pulse and BTB valid bits; only these are cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc          <= RESET_PC[XLEN-1:0];
      r_fetch_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_btb_valid   <= '0;
    end else begin
      r_pc          <= w_pc_next;
      r_fetch_valid <= 1'b1;
      r_misalign    <= w_misalign_next;
      if (upd_en_i) begin
        if (upd_taken_i) begin
          r_btb_valid[w_upd_idx] <= 1'b1;
        end else if (w_upd_tag_match) begin
          r_btb_valid[w_upd_idx] <= 1'b0;
        end else begin
          r_btb_valid[w_upd_idx] <= r_btb_valid[w_upd_idx];
        end
      end
    end
  end

  // Tag/target storage; an update that coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && upd_en_i && upd_taken_i) begin
      r_btb_tag[w_upd_idx] <= w_upd_tag;
      r_btb_tgt[w_upd_idx] <= upd_target_i[XLEN-1:2];
    end
  end

  assign pc_o          = r_pc;
  assign fetch_valid_o = r_fetch_valid;
  assign misalign_o    = r_misalign;
  assign pred_taken_o  = w_hit;
  assign pred_target_o = w_pred_target;

endmodule

// File: tb/tb_pc_gen_btb.sv
// Directed self-checking bench for pc_gen_btb: reset, sequencing, priority,
// BTB train/alias/invalidate, address wrap and reset during activity.
module tb_pc_gen_btb;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        jump_en_i;
  logic [63:0] jump_addr_i;
  logic        stall_en_i;
  logic        fetch_ready_i;
  logic        fetch_valid_o;
  logic [63:0] pc_o;
  logic        pred_taken_o;
  logic [63:0] pred_target_o;
  logic        misalign_o;
  logic        upd_en_i;
  logic [63:0] upd_pc_i;
  logic        upd_taken_i;
  logic [63:0] upd_target_i;

  int checks = 0;
  int errors = 0;

  pc_gen_btb #(.XLEN(64), .RESET_PC(RST_PC), .BTB_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .stall_en_i(stall_en_i), .fetch_ready_i(fetch_ready_i),
    .fetch_valid_o(fetch_valid_o), .pc_o(pc_o),
    .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .misalign_o(misalign_o),
    .upd_en_i(upd_en_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    jump_en_i = 1'b0; jump_addr_i = 64'd0; stall_en_i = 1'b0; fetch_ready_i = 1'b0;
    upd_en_i = 1'b0; upd_pc_i = 64'd0; upd_taken_i = 1'b0; upd_target_i = 64'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (3) step();
    checks++; if (pc_o !== RST_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_o, RST_PC); end
    checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", fetch_valid_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign_o); end
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL reset_pred got %b exp 0", pred_taken_o); end
    rst = 1'b1;
    #2;
    checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL release_valid_early got %b exp 0", fetch_valid_o); end
    step();
    checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL release_valid got %b exp 1", fetch_valid_o); end
    checks++; if (pc_o !== RST_PC) begin errors++; $display("FAIL release_pc got %h exp %h", pc_o, RST_PC); end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc [3];
    exp_pc[0] = 64'h8000_0004; exp_pc[1] = 64'h8000_0008; exp_pc[2] = 64'h8000_000C;
    fetch_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc_o !== exp_pc[i]) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc_o, exp_pc[i]); end
    end
    fetch_ready_i = 1'b0;
    repeat (2) step();
    checks++; if (pc_o !== 64'h8000_000C) begin errors++; $display("FAIL hold_pc got %h exp 8000000c", pc_o); end
    checks++; if (pred_target_o !== 64'h8000_0010) begin errors++; $display("FAIL hold_plus4 got %h exp 80000010", pred_target_o); end
  endtask

  task automatic test_priority();
    jump_en_i = 1'b1; jump_addr_i = 64'h8000_0102; stall_en_i = 1'b1; fetch_ready_i = 1'b1;
    step();
    checks++; if (pc_o !== 64'h8000_0100) begin errors++; $display("FAIL jump_pc got %h exp 80000100", pc_o); end
    checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL jump_misalign got %b exp 1", misalign_o); end
    jump_en_i = 1'b0;
    step();
    checks++; if (pc_o !== 64'h8000_0100) begin errors++; $display("FAIL stall_pc got %h exp 80000100", pc_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL misalign_pulse got %b exp 0", misalign_o); end
    stall_en_i = 1'b0; fetch_ready_i = 1'b0;
  endtask

  task automatic test_btb_train();
    jump_en_i = 1'b1; jump_addr_i = 64'h8000_0008;
    step();
    jump_en_i = 1'b0;
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL pretrain_pred got %b exp 0", pred_taken_o); end
    upd_en_i = 1'b1; upd_pc_i = 64'h8000_0008; upd_taken_i = 1'b1; upd_target_i = 64'h8000_1000;
    step();
    upd_en_i = 1'b0;
    checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL train_pred got %b exp 1", pred_taken_o); end
    checks++; if (pred_target_o !== 64'h8000_1000) begin errors++; $display("FAIL train_target got %h exp 80001000", pred_target_o); end
    fetch_ready_i = 1'b1;
    step();
    fetch_ready_i = 1'b0;
    checks++; if (pc_o !== 64'h8000_1000) begin errors++; $display("FAIL predicted_pc got %h exp 80001000", pc_o); end
    jump_en_i = 1'b1; jump_addr_i = 64'h8000_0048;
    step();
    jump_en_i = 1'b0;
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL alias_pred got %b exp 0", pred_taken_o); end
    checks++; if (pred_target_o !== 64'h8000_004C) begin errors++; $display("FAIL alias_target got %h exp 8000004c", pred_target_o); end
  endtask

  task automatic test_invalidate();
    upd_en_i = 1'b1; upd_pc_i = 64'h8000_0048; upd_taken_i = 1'b0;
    jump_en_i = 1'b1; jump_addr_i = 64'h8000_0008;
    step();
    jump_en_i = 1'b0;
    checks++; if (pc_o !== 64'h8000_0008) begin errors++; $display("FAIL inv_jump_pc got %h exp 80000008", pc_o); end
    checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL inv_alias_kept got %b exp 1", pred_taken_o); end
    upd_pc_i = 64'h8000_0008;
    step();
    upd_en_i = 1'b0;
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL inv_cleared got %b exp 0", pred_taken_o); end
    fetch_ready_i = 1'b1;
    step();
    fetch_ready_i = 1'b0;
    checks++; if (pc_o !== 64'h8000_000C) begin errors++; $display("FAIL inv_next_pc got %h exp 8000000c", pc_o); end
  endtask

  task automatic test_wrap();
    jump_en_i = 1'b1; jump_addr_i = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    jump_en_i = 1'b0;
    checks++; if (pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_jump got %h exp fffffffffffffffc", pc_o); end
    checks++; if (pred_target_o !== 64'd0) begin errors++; $display("FAIL wrap_target got %h exp 0", pred_target_o); end
    fetch_ready_i = 1'b1;
    step();
    fetch_ready_i = 1'b0;
    checks++; if (pc_o !== 64'd0) begin errors++; $display("FAIL wrap_pc got %h exp 0", pc_o); end
  endtask

  task automatic test_reset_midop();
    jump_en_i = 1'b1; jump_addr_i = RST_PC;
    upd_en_i = 1'b1; upd_pc_i = RST_PC; upd_taken_i = 1'b1; upd_target_i = 64'h8000_2006;
    step();
    jump_en_i = 1'b0; upd_en_i = 1'b0;
    checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL mid_pred got %b exp 1", pred_taken_o); end
    checks++; if (pred_target_o !== 64'h8000_2004) begin errors++; $display("FAIL mid_target_align got %h exp 80002004", pred_target_o); end
    rst = 1'b0;
    jump_en_i = 1'b1; jump_addr_i = 64'h0000_0000_0000_0123;
    step();
    clear_inputs();
    checks++; if (pc_o !== RST_PC) begin errors++; $display("FAIL mid_rst_pc got %h exp %h", pc_o, RST_PC); end
    checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", fetch_valid_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mid_rst_misalign got %b exp 0", misalign_o); end
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL mid_rst_pred got %b exp 0", pred_taken_o); end
    rst = 1'b1;
    step();
    checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL mid_release_valid got %b exp 1", fetch_valid_o); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_priority();
    test_btb_train();
    test_invalidate();
    test_wrap();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
